// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU text-mode command sequencer.
package gpu_pkg;

    // Default screen geometry and RAM sizing.
    localparam int        COLS_DEF = 40;
    localparam int        ROWS_DEF = 25;
    localparam int        AW_DEF   = 12;
    localparam logic [7:0] FILL_DEF = 8'h00;

    // Cursor register widths, fixed by the cur_x / cur_y ports.
    localparam int XW = 6;
    localparam int YW = 5;

    // Text-mode opcodes.
    localparam logic [15:0] OP_INIT = 16'h00C0;
    localparam logic [15:0] OP_PUT  = 16'h00C1;
    localparam logic [15:0] OP_BS   = 16'h00C2;
    localparam logic [15:0] OP_SETY = 16'h00C3;
    localparam logic [15:0] OP_SETX = 16'h00C4;
    localparam logic [15:0] OP_CLS  = 16'h00C5;
    localparam logic [15:0] OP_NL   = 16'h00C6;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WRITE,
        ST_CLEAR
    } state_e;

    // Cursor update requests, one per cycle.
    typedef enum logic [2:0] {
        CUR_NONE,
        CUR_INC,
        CUR_DEC,
        CUR_NL,
        CUR_SETX,
        CUR_SETY,
        CUR_ZERO
    } cur_op_e;

endpackage

// File: rtl/gpu_cursor.sv
// Text cursor: holds column/row, applies one update per cycle and
// exposes the linear display-RAM pointer for the current cell.
module gpu_cursor
    import gpu_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic          clk,
    input  logic          clr,
    input  cur_op_e       cur_op_i,
    input  logic [15:0]   set_val_i,
    output logic [XW-1:0] cur_x_o,
    output logic [YW-1:0] cur_y_o,
    output logic [AW-1:0] ptr_o,
    output logic          at_origin_o
);

    localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    // Next cursor position for the requested update.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        x_d = x_q;
        y_d = y_q;
        unique case (cur_op_i)
            CUR_INC: begin
                if (x_q == X_MAX) begin
                    x_d = '0;
                    y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            CUR_DEC: begin
                if (x_q != '0) begin
                    x_d = x_q - 1'b1;
                end else if (y_q != '0) begin
                    x_d = X_MAX;
                    y_d = y_q - 1'b1;
                end
            end
            CUR_NL: begin
                x_d = '0;
                y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
            end
            CUR_SETX: x_d = (set_val_i > 16'(COLS - 1)) ? X_MAX : set_val_i[XW-1:0];
            CUR_SETY: y_d = (set_val_i > 16'(ROWS - 1)) ? Y_MAX : set_val_i[YW-1:0];
            CUR_ZERO: begin
                x_d = '0;
                y_d = '0;
            end
            default: ;
        endcase
    end

    // Cursor registers with synchronous reset to the origin.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (clr) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // The 40-column screen uses the shift-add form y*32 + y*8 + x.
    if (COLS == 40) begin : g_ptr_shift
        assign ptr_o = (AW'(y_q) << 5) + (AW'(y_q) << 3) + AW'(x_q);
    end else begin : g_ptr_mul
        assign ptr_o = AW'(y_q) * AW'(COLS) + AW'(x_q);
    end

    assign cur_x_o     = x_q;
    assign cur_y_o     = y_q;
    assign at_origin_o = (x_q == '0) && (y_q == '0);

endmodule

// File: rtl/gpu_text_cmd_seq.sv
// Text-mode command sequencer: accepts cmd/param pairs, runs the text
// opcodes as display-RAM writes and yields the RAM port to scan-out.
module gpu_text_cmd_seq
    import gpu_pkg::*;
#(
    parameter int         COLS = COLS_DEF,
    parameter int         ROWS = ROWS_DEF,
    parameter int         AW   = AW_DEF,
    parameter logic [7:0] FILL = FILL_DEF
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [15:0]   cmd,
    input  logic [15:0]   param,
    input  logic          scan_req,
    input  logic [AW-1:0] scan_addr,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic          busy
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(COLS * ROWS - 1);

    state_e        state_q, state_d;
    logic [15:0]   op_q, op_d;
    logic [15:0]   param_q, param_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [AW-1:0] cnt_q, cnt_d;

    cur_op_e       cur_op;
    logic [AW-1:0] ptr;
    logic          at_origin;
    logic [AW-1:0] waddr;
    logic          we;

    gpu_cursor #(
        .COLS (COLS),
        .ROWS (ROWS),
        .AW   (AW)
    ) u_cursor (
        .clk         (clk),
        .clr         (clr),
        .cur_op_i    (cur_op),
        .set_val_i   (param_q),
        .cur_x_o     (cur_x),
        .cur_y_o     (cur_y),
        .ptr_o       (ptr),
        .at_origin_o (at_origin)
    );

    // Next-state, cursor request and write-port control.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        param_d = param_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        cur_op  = CUR_NONE;
        waddr   = ptr;
        we      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd;
                    param_d = param;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                state_d = ST_IDLE;
                case (op_q)
                    OP_INIT: begin
                        // A zero operand is a text-mode init, i.e. a clear.
                        if (param_q == '0) begin
                            cnt_d   = '0;
                            wdata_d = FILL;
                            state_d = ST_CLEAR;
                        end
                    end
                    OP_PUT: begin
                        wdata_d = param_q[7:0];
                        state_d = ST_WRITE;
                    end
                    OP_BS: begin
                        // Step back now so the WRITE cycle targets the new cell.
                        if (!at_origin) begin
                            cur_op  = CUR_DEC;
                            wdata_d = FILL;
                            state_d = ST_WRITE;
                        end
                    end
                    OP_SETY: cur_op = CUR_SETY;
                    OP_SETX: cur_op = CUR_SETX;
                    OP_CLS: begin
                        cnt_d   = '0;
                        wdata_d = FILL;
                        state_d = ST_CLEAR;
                    end
                    OP_NL:   cur_op = CUR_NL;
                    default: ;
                endcase
            end

            ST_WRITE: begin
                if (!scan_req) begin
                    we      = 1'b1;
                    state_d = ST_IDLE;
                    if (op_q == OP_PUT) begin
                        cur_op = CUR_INC;
                    end
                end
            end

            ST_CLEAR: begin
                waddr = cnt_q;
                if (!scan_req) begin
                    we = 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        cur_op  = CUR_ZERO;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers; reset aborts any operation in progress.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            param_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            param_q <= param_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Scan-out owns the address whenever it asks; writes are already gated off then.
    assign mem_addr  = scan_req ? scan_addr : waddr;
    assign mem_we    = we;
    assign mem_wdata = wdata_q;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

endmodule
